fp_add_unpack_stage: RTL and testbench
======================================

Name: fp_add_unpack_stage

Overview:
- First stage of the FP adder preparer pipeline, directly upstream of the special-case analyser.
- Accepts two packed IEEE-754 operands and an add/sub command, then decodes them: sign, exponent, mantissa with hidden bit, NaN/inf/zero flags.
- Orders the operands so op_1 has the larger magnitude and computes the exponent difference.
- Registers the result behind a 2-entry valid/ready skid buffer. The registered input ready keeps timing paths local.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa field width (W = 1+EXP_W+MAN_W is the packed operand width)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  stage can accept; registered
in_a  in  W  packed operand A {s,e,m}
in_b  in  W  packed operand B
in_sub  in  1  1 = A−B (B sign inverted before decode)
out_valid  out  1  decoded pair valid
out_ready  in  1  downstream accepts
op_1_s, op_2_s  out  1  signs after sub inversion and swap
op_1_NaN, op_2_NaN  out  1  exponent all ones, mantissa != 0
op_1_inf, op_2_inf  out  1  exponent all ones, mantissa == 0
op_1_zero, op_2_zero  out  1  exponent == 0, mantissa == 0
op_1_e, op_2_e  out  EXP_W  effective exponent (1 if raw exponent 0, else raw)
op_1_m, op_2_m  out  MAN_W+1  {hidden, mantissa}; hidden = (raw exponent != 0)
exp_diff  out  EXP_W  op_1_e − op_2_e, always ≥0 after swap
swap  out  1  1 = op_1 came from B

Behaviour:
- Decode is combinational on the input side. B's sign is XORed with in_sub first. Only decoded fields are stored; raw operands are not kept.
- Magnitude order compares raw {e,m} of A and B as unsigned (EXP_W+MAN_W) bits.
  - B > A: swap = 1, B's fields go to op_1.
  - Equal magnitude: swap = 0, no swap.
  - NaN and inf operands are ordered by the same rule; the flags travel with their operand.
- exp_diff uses the effective exponents and is computed with no wrap. Example: denormal vs exponent-1 value gives exp_diff = 0.
- Handshake:
  - Input fires on in_valid & in_ready.
  - Output fires on out_valid & out_ready.
  - Output fields are held stable while out_valid & ~out_ready.
- Storage is a main register (drives the outputs) plus one skid register. The state machine is:
  - EMPTY: in fire → ONE (main ← input).
  - ONE:
    - in fire & out fire → ONE (main ← input).
    - in fire & ~out_ready → TWO (skid ← input).
    - out fire, no input → EMPTY.
    - neither → ONE.
  - TWO: in fire is impossible because in_ready = 0. out fire → ONE (main ← skid).
- out_valid = (state != EMPTY).
- in_ready = (state != TWO), taken from the state flops only. in_ready never depends combinationally on out_ready.
- Latency and throughput:
  - Latency is 1 cycle from input fire (in EMPTY) to out_valid.
  - Full throughput of 1 pair/cycle holds while out_ready = 1.
  - Order is strictly FIFO; no pair is lost or duplicated.
- Reset: rst_n low asynchronously forces EMPTY.
  - out_valid = 0, in_ready = 1.
  - All data outputs = 0.
- Reset mid-operation discards main and skid contents; nothing is emitted after release until a new input fires.
- Data registers may be left unreset only if the outputs are masked; the required behaviour is that all outputs read 0 during and after reset until the first load.

Test Plan:
- in_a = 0x3F800000 (1.0), in_b = 0x40000000 (2.0), in_sub = 0, out_ready = 1 → next cycle out_valid = 1 with:
  - swap = 1, op_1_e = 128, op_2_e = 127, exp_diff = 1;
  - op_1_m = op_2_m = 0x800000;
  - all NaN/inf/zero flags = 0.
- in_a = in_b = 0x7F800000 (+inf), in_sub = 1 → op_1_inf = op_2_inf = 1, op_1_s = 0, op_2_s = 1, swap = 0. Separately, in_a = 0x7FC00000 → op_1_NaN = 1, op_1_inf = 0.
- in_a = 0x00000001, in_b = 0x00000000 → the following values:
  - op_1_e = 1, op_1_m = 0x000001, op_1_zero = 0;
  - op_2_zero = 1, op_2_e = 1;
  - exp_diff = 0, swap = 0.
- out_ready held 0, in_valid = 1 with 4 distinct pairs streamed:
  - cycles 0 and 1 accepted; in_ready = 0 from cycle 2;
  - after out_ready rises, 4 pairs emerge in order with no gaps, and outputs are stable while stalled.
- Continuous in_valid = 1 and out_ready = 1 for 10 pairs → 10 outputs on 10 consecutive cycles, in_ready constantly 1.
- In state TWO, drive rst_n = 0 for 1 cycle mid-clock → out_valid drops immediately and in_ready = 1. After release, with no input, out_valid stays 0. The next input emerges alone after 1 cycle.

Source files
------------

// File: rtl/fp_add_unpack_stage.sv
// FP adder front stage: decodes two packed operands, orders them by magnitude
// and presents the result behind a 2-entry valid/ready skid buffer.
module fp_add_unpack_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   op_1_s,
    output logic                   op_2_s,
    output logic                   op_1_NaN,
    output logic                   op_2_NaN,
    output logic                   op_1_inf,
    output logic                   op_2_inf,
    output logic                   op_1_zero,
    output logic                   op_2_zero,
    output logic [EXP_W-1:0]       op_1_e,
    output logic [EXP_W-1:0]       op_2_e,
    output logic [MAN_W:0]         op_1_m,
    output logic [MAN_W:0]         op_2_m,
    output logic [EXP_W-1:0]       exp_diff,
    output logic                   swap
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic             s;
        logic             nan;
        logic             inf;
        logic             zero;
        logic [EXP_W-1:0] e;
        logic [MAN_W:0]   m;
    } dec_t;

    typedef struct packed {
        dec_t             op1;
        dec_t             op2;
        logic [EXP_W-1:0] exp_diff;
        logic             swap;
    } pair_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic dec_t decode(input logic s, input logic [EXP_W-1:0] e,
                                    input logic [MAN_W-1:0] m);
        dec_t d;
        d.s    = s;
        d.nan  = (&e) & (|m);
        d.inf  = (&e) & ~(|m);
        d.zero = ~(|e) & ~(|m);
        d.e    = (|e) ? e : EXP_W'(1);
        d.m    = {|e, m};
        return d;
    endfunction

    dec_t   dec_a, dec_b;
    pair_t  in_pair;
    logic   b_gt_a;

    // Raw {e,m} compare orders denormals, NaN and inf consistently with normals.
    always_comb begin
        dec_a   = decode(in_a[W-1], in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
        dec_b   = decode(in_b[W-1] ^ in_sub, in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
        b_gt_a  = in_b[W-2:0] > in_a[W-2:0];
        in_pair.swap     = b_gt_a;
        in_pair.op1      = b_gt_a ? dec_b : dec_a;
        in_pair.op2      = b_gt_a ? dec_a : dec_b;
        in_pair.exp_diff = in_pair.op1.e - in_pair.op2.e;
    end

    state_t state_q, state_d;
    pair_t  main_q, main_d, skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   in_fire, out_fire;

    always_comb begin
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        case (state_q)
            EMPTY: if (in_fire) begin
                main_d  = in_pair;
                state_d = ONE;
            end
            ONE: begin
                if (in_fire && out_ready) begin
                    main_d = in_pair;
                end else if (in_fire) begin
                    skid_d  = in_pair;
                    state_d = TWO;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (out_fire) begin
                main_d  = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        // Handshake flags come straight from flops so in_ready never sees out_ready.
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign op_1_s    = main_q.op1.s;
    assign op_2_s    = main_q.op2.s;
    assign op_1_NaN  = main_q.op1.nan;
    assign op_2_NaN  = main_q.op2.nan;
    assign op_1_inf  = main_q.op1.inf;
    assign op_2_inf  = main_q.op2.inf;
    assign op_1_zero = main_q.op1.zero;
    assign op_2_zero = main_q.op2.zero;
    assign op_1_e    = main_q.op1.e;
    assign op_2_e    = main_q.op2.e;
    assign op_1_m    = main_q.op1.m;
    assign op_2_m    = main_q.op2.m;
    assign exp_diff  = main_q.exp_diff;
    assign swap      = main_q.swap;

endmodule

// File: tb/tb_fp_add_unpack_stage.sv
// Bench for fp_add_unpack_stage: directed test-plan steps plus random traffic
// checked against a FIFO-of-expected-pairs model computed from IEEE field rules.
module tb_fp_add_unpack_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid;
    logic        op_1_s, op_2_s, op_1_NaN, op_2_NaN, op_1_inf, op_2_inf, op_1_zero, op_2_zero;
    logic [7:0]  op_1_e, op_2_e, exp_diff;
    logic [23:0] op_1_m, op_2_m;
    logic        swap;

    fp_add_unpack_stage #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .op_1_s(op_1_s), .op_2_s(op_2_s),
        .op_1_NaN(op_1_NaN), .op_2_NaN(op_2_NaN), .op_1_inf(op_1_inf),
        .op_2_inf(op_2_inf), .op_1_zero(op_1_zero), .op_2_zero(op_2_zero),
        .op_1_e(op_1_e), .op_2_e(op_2_e), .op_1_m(op_1_m), .op_2_m(op_2_m),
        .exp_diff(exp_diff), .swap(swap)
    );

    always #5 clk = ~clk;

    typedef logic [80:0] vec_t;
    vec_t q[$];
    int   checks = 0, errors = 0;
    bit   loaded = 1'b0;

    function automatic vec_t obs_vec();
        return {op_1_s, op_2_s, op_1_NaN, op_2_NaN, op_1_inf, op_2_inf, op_1_zero,
                op_2_zero, op_1_e, op_2_e, op_1_m, op_2_m, exp_diff, swap};
    endfunction

    function automatic vec_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb, x, y;
        logic        sw;
        logic [7:0]  e1, e2, f1, f2, d;
        logic [22:0] m1, m2;
        bb = {b[31] ^ sub, b[30:0]};
        sw = (b[30:0] > a[30:0]);
        x  = sw ? bb : a;
        y  = sw ? a : bb;
        e1 = x[30:23]; m1 = x[22:0];
        e2 = y[30:23]; m2 = y[22:0];
        f1 = (e1 == 0) ? 8'd1 : e1;
        f2 = (e2 == 0) ? 8'd1 : e2;
        d  = 8'(int'(f1) - int'(f2));
        return {x[31], y[31],
                (e1 == 255 && m1 != 0), (e2 == 255 && m2 != 0),
                (e1 == 255 && m1 == 0), (e2 == 255 && m2 == 0),
                (e1 == 0 && m1 == 0),   (e2 == 0 && m2 == 0),
                f1, f2, {e1 != 0, m1}, {e2 != 0, m2}, d, sw};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 5))
            0: e = 8'd0;
            1: e = 8'd1;
            2: e = 8'd254;
            3: e = 8'd255;
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already set; advances one cycle.
    task automatic step();
        bit inf, outf;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("data", obs_vec(), q[0]);
        else if (!loaded) chk("zero_out", obs_vec(), 0);
        inf  = in_valid && (q.size() < 2);
        outf = (q.size() > 0) && out_ready;
        if (outf) void'(q.pop_front());
        if (inf) begin
            q.push_back(ref_model(in_a, in_b, in_sub));
            loaded = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] pa[4], pb[4];
        int idx;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", obs_vec(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1.0 + 2.0
        out_ready = 1; in_valid = 1; in_sub = 0;
        in_a = 32'h3F800000; in_b = 32'h40000000;
        step();
        in_valid = 0;
        chk("t1_valid", out_valid, 1);
        chk("t1_swap", swap, 1);
        chk("t1_op1e", op_1_e, 128);
        chk("t1_op2e", op_2_e, 127);
        chk("t1_diff", exp_diff, 1);
        chk("t1_op1m", op_1_m, 24'h800000);
        chk("t1_op2m", op_2_m, 24'h800000);
        chk("t1_flags", {op_1_NaN, op_2_NaN, op_1_inf, op_2_inf, op_1_zero, op_2_zero}, 0);
        step();

        // +inf - +inf
        in_valid = 1; in_sub = 1; in_a = 32'h7F800000; in_b = 32'h7F800000;
        step();
        in_valid = 0;
        chk("t2_inf", {op_1_inf, op_2_inf}, 2'b11);
        chk("t2_s1", op_1_s, 0);
        chk("t2_s2", op_2_s, 1);
        chk("t2_swap", swap, 0);
        step();

        in_valid = 1; in_sub = 0; in_a = 32'h7FC00000; in_b = 32'h3F800000;
        step();
        in_valid = 0;
        chk("t2b_nan", op_1_NaN, 1);
        chk("t2b_inf", op_1_inf, 0);
        step();

        // smallest denormal vs zero
        in_valid = 1; in_a = 32'h00000001; in_b = 32'h00000000;
        step();
        in_valid = 0;
        chk("t3_op1e", op_1_e, 1);
        chk("t3_op1m", op_1_m, 24'h000001);
        chk("t3_op1z", op_1_zero, 0);
        chk("t3_op2z", op_2_zero, 1);
        chk("t3_op2e", op_2_e, 1);
        chk("t3_diff", exp_diff, 0);
        chk("t3_swap", swap, 0);
        step();

        // Stall with four distinct pairs queued behind out_ready = 0
        for (int i = 0; i < 4; i++) begin
            pa[i] = 32'h3F800000 + 32'(i * 32'h00100000);
            pb[i] = 32'h40400000 - 32'(i * 32'h00080000);
        end
        out_ready = 0; idx = 0;
        for (int c = 0; c < 30 && (idx < 4 || q.size() > 0); c++) begin
            bit acc;
            if (c == 6) out_ready = 1;
            in_valid = (idx < 4);
            if (idx < 4) begin in_a = pa[idx]; in_b = pb[idx]; end
            if (c == 2 || c == 3) chk("stall_in_ready", in_ready, 0);
            acc = in_valid && (q.size() < 2);
            step();
            if (acc) idx++;
        end
        in_valid = 0;
        chk("stall_all_in", idx, 4);
        chk("stall_drained", q.size(), 0);

        // Full throughput
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_a = rand_fp(); in_b = rand_fp(); in_sub = 1'($urandom);
            step();
        end
        in_valid = 0;
        step();

        // Reset while holding two entries
        out_ready = 0; in_sub = 0;
        in_valid = 1; in_a = 32'h41000000; in_b = 32'h40000000; step();
        in_a = 32'h42000000; step();
        in_valid = 0;
        chk("pre_rst_full", in_ready, 0);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", obs_vec(), 0);
        q.delete();
        loaded = 1'b0;
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1; in_a = 32'hC0A00000; in_b = 32'h3F000000; in_sub = 1;
        step();
        in_valid = 0;
        chk("post_rst_one", out_valid, 1);
        step();
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_a      = rand_fp();
            in_b      = ($urandom_range(0, 7) == 0) ? {~in_a[31], in_a[30:0]} : rand_fp();
            in_sub    = 1'($urandom);
            step();
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
